// File: rtl/shift_issue_buffer.sv
// Reservation buffer for shift micro-ops: lowest-free-slot allocation, indexed release, flush.
// Optional age matrix and oldest-slot output when SHIFT_ISSUE_BUF_AGE_EN is defined.
`ifndef SHIFT_ISSUE_DEPTH
`define SHIFT_ISSUE_DEPTH 4
`endif
`ifndef SHIFT_ISSUE_INFO_DW
`define SHIFT_ISSUE_INFO_DW 32
`endif

module shift_issue_buffer #(
  parameter int DEPTH = `SHIFT_ISSUE_DEPTH,
  parameter int DW    = `SHIFT_ISSUE_INFO_DW
) (
  input  logic                     CLK,
  input  logic                     RSTn,
  input  logic                     shift_dispat_push,
  input  logic [DW-1:0]            shift_dispat_info,
  output logic                     shift_buffer_full,
  input  logic                     shift_buffer_pop,
  input  logic [$clog2(DEPTH)-1:0] shift_buffer_pop_index,
  input  logic                     flush,
  output logic [DEPTH-1:0]         shift_buffer_malloc,
  output logic [DW*DEPTH-1:0]      shift_issue_info
`ifdef SHIFT_ISSUE_BUF_AGE_EN
  ,
  output logic [DEPTH-1:0]         shift_buffer_oldest
`endif
);

  localparam int IW = $clog2(DEPTH);

  logic [DEPTH-1:0] malloc_reg;
  logic [DEPTH-1:0] malloc_next;
  logic [DW-1:0]    info_reg [DEPTH];
  logic [IW-1:0]    free_idx;
  logic             push_ok;
  logic             pop_ok;
  logic [DEPTH-1:0] push_sel;
  logic [DEPTH-1:0] pop_sel;

  assign shift_buffer_full   = &malloc_reg;
  assign shift_buffer_malloc = malloc_reg;

  // Full is judged on registered state, so a same-cycle pop never frees room for a push.
  assign push_ok = shift_dispat_push & ~shift_buffer_full & ~flush;
  assign pop_ok  = shift_buffer_pop & malloc_reg[shift_buffer_pop_index] & ~flush;

  always_comb begin
    free_idx = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!malloc_reg[i]) free_idx = IW'(i);
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_slot
      assign push_sel[gi] = push_ok & (free_idx == IW'(gi));
      assign pop_sel[gi]  = pop_ok & (shift_buffer_pop_index == IW'(gi));
      assign shift_issue_info[DW*gi +: DW] = info_reg[gi];
    end
  endgenerate

  always_comb begin
    malloc_next = malloc_reg;
    if (flush) begin
      malloc_next = '0;
    end else begin
      malloc_next = (malloc_reg & ~pop_sel) | push_sel;
    end
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      malloc_reg <= '0;
      for (int i = 0; i < DEPTH; i++) info_reg[i] <= '0;
    end else begin
      malloc_reg <= malloc_next;
      for (int i = 0; i < DEPTH; i++) begin
        if (push_sel[i]) info_reg[i] <= shift_dispat_info;
      end
    end
  end

`ifdef SHIFT_ISSUE_BUF_AGE_EN
  // older_reg[i][j] = 1: slot i was pushed before slot j. Stale rows are masked by malloc.
  logic [DEPTH-1:0] older_reg  [DEPTH];
  logic [DEPTH-1:0] older_next [DEPTH];
  logic [DEPTH-1:0] younger_than_valid;

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      for (int j = 0; j < DEPTH; j++) begin
        older_next[i][j] = older_reg[i][j];
        if (push_sel[i]) begin
          older_next[i][j] = 1'b0;
        end else if (push_sel[j]) begin
          older_next[i][j] = malloc_reg[i];
        end
      end
    end
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      for (int i = 0; i < DEPTH; i++) older_reg[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) older_reg[i] <= older_next[i];
    end
  end

  always_comb begin
    younger_than_valid = '0;
    for (int i = 0; i < DEPTH; i++) begin
      for (int j = 0; j < DEPTH; j++) begin
        if (malloc_reg[j] && older_reg[j][i]) younger_than_valid[i] = 1'b1;
      end
    end
  end

  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_oldest
      assign shift_buffer_oldest[gi] = malloc_reg[gi] & ~younger_than_valid[gi];
    end
  endgenerate
`endif

endmodule

// File: tb/tb_shift_issue_buffer.sv
// Directed test-plan steps plus random traffic, checked each cycle against a slot/timestamp model.
module tb_shift_issue_buffer;
  localparam int DEPTH = 4;
  localparam int DW    = 32;
  localparam int IW    = 2;

  logic                  CLK = 1'b0;
  logic                  RSTn = 1'b0;
  logic                  push = 1'b0;
  logic [DW-1:0]         info = '0;
  logic                  pop = 1'b0;
  logic [IW-1:0]         pop_idx = '0;
  logic                  fl = 1'b0;
  logic                  full;
  logic [DEPTH-1:0]      malloc;
  logic [DW*DEPTH-1:0]   issue_info;
`ifdef SHIFT_ISSUE_BUF_AGE_EN
  logic [DEPTH-1:0]      oldest;
`endif

  shift_issue_buffer #(.DEPTH(DEPTH), .DW(DW)) dut (
    .CLK(CLK),
    .RSTn(RSTn),
    .shift_dispat_push(push),
    .shift_dispat_info(info),
    .shift_buffer_full(full),
    .shift_buffer_pop(pop),
    .shift_buffer_pop_index(pop_idx),
    .flush(fl),
    .shift_buffer_malloc(malloc),
    .shift_issue_info(issue_info)
`ifdef SHIFT_ISSUE_BUF_AGE_EN
    ,
    .shift_buffer_oldest(oldest)
`endif
  );

  always #5 CLK = ~CLK;

  int passed = 0;
  int total  = 0;

  // Reference model: per-slot valid flag, record, and push timestamp.
  bit            m_valid [DEPTH];
  logic [DW-1:0] m_info  [DEPTH];
  int            m_stamp [DEPTH];
  int            stamp_ctr;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic m_reset();
    for (int i = 0; i < DEPTH; i++) begin
      m_valid[i] = 1'b0;
      m_info[i]  = '0;
      m_stamp[i] = 0;
    end
    stamp_ctr = 0;
  endtask

  function automatic logic [DEPTH-1:0] m_malloc();
    logic [DEPTH-1:0] v;
    for (int i = 0; i < DEPTH; i++) v[i] = m_valid[i];
    return v;
  endfunction

  function automatic logic [DW*DEPTH-1:0] m_infovec();
    logic [DW*DEPTH-1:0] v;
    for (int i = 0; i < DEPTH; i++) v[DW*i +: DW] = m_info[i];
    return v;
  endfunction

  function automatic logic [DEPTH-1:0] m_oldest();
    logic [DEPTH-1:0] v;
    int best;
    v = '0;
    best = -1;
    for (int i = 0; i < DEPTH; i++) begin
      if (m_valid[i] && (best < 0 || m_stamp[i] < m_stamp[best])) best = i;
    end
    if (best >= 0) v[best] = 1'b1;
    return v;
  endfunction

  // One clock edge of the buffer, evaluated on the model's pre-edge state.
  task automatic model_edge();
    bit was_full;
    int k;
    was_full = 1'b1;
    k = -1;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!m_valid[i]) begin
        was_full = 1'b0;
        k = i;
      end
    end
    if (fl) begin
      for (int i = 0; i < DEPTH; i++) m_valid[i] = 1'b0;
    end else begin
      if (pop && m_valid[pop_idx]) m_valid[pop_idx] = 1'b0;
      if (push && !was_full) begin
        m_valid[k] = 1'b1;
        m_info[k]  = info;
        m_stamp[k] = stamp_ctr;
        stamp_ctr++;
      end
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".malloc"}, 128'(malloc), 128'(m_malloc()));
    chk({tag, ".full"}, 128'(full), 128'(&m_malloc()));
    chk({tag, ".info"}, 128'(issue_info), 128'(m_infovec()));
`ifdef SHIFT_ISSUE_BUF_AGE_EN
    chk({tag, ".oldest"}, 128'(oldest), 128'(m_oldest()));
`endif
  endtask

  task automatic cycle(input string tag);
    @(posedge CLK);
    model_edge();
    #1;
    check_all(tag);
  endtask

  task automatic drive(input string tag, input logic p, input logic [DW-1:0] d,
                       input logic po, input logic [IW-1:0] idx, input logic f);
    push = p; info = d; pop = po; pop_idx = idx; fl = f;
    cycle(tag);
  endtask

  initial begin
    m_reset();
    #12;
    check_all("reset");
    chk("reset.malloc_lit", 128'(malloc), 128'(4'b0000));
    @(negedge CLK);
    RSTn = 1'b1;

    // Fill A..D
    drive("pushA", 1, 32'hA, 0, 0, 0); chk("pushA.lit", 128'(malloc), 128'(4'b0001));
    drive("pushB", 1, 32'hB, 0, 0, 0); chk("pushB.lit", 128'(malloc), 128'(4'b0011));
    drive("pushC", 1, 32'hC, 0, 0, 0); chk("pushC.lit", 128'(malloc), 128'(4'b0111));
    drive("pushD", 1, 32'hD, 0, 0, 0); chk("pushD.lit", 128'(malloc), 128'(4'b1111));
    chk("full.lit", 128'(full), 128'(1'b1));
    chk("info.lit", 128'(issue_info), 128'({32'hD, 32'hC, 32'hB, 32'hA}));

    // Push while full with pop: refused, then accepted into freed slot
    drive("pushE_pop2", 1, 32'hE, 1, 2, 0); chk("pushE_pop2.lit", 128'(malloc), 128'(4'b1011));
    drive("pushE_hold", 1, 32'hE, 0, 0, 0); chk("pushE_hold.lit", 128'(malloc), 128'(4'b1111));
    chk("slot2E.lit", 128'(issue_info[64 +: 32]), 128'(32'hE));

    // Reach 0101, then push F with pop 0
    drive("pop1", 0, 0, 1, 1, 0);
    drive("pop3", 0, 0, 1, 3, 0); chk("pop3.lit", 128'(malloc), 128'(4'b0101));
    drive("pushF_pop0", 1, 32'hF, 1, 0, 0); chk("pushF.lit", 128'(malloc), 128'(4'b0110));
    chk("slot1F.lit", 128'(issue_info[32 +: 32]), 128'(32'hF));

    // Pop of an empty slot is ignored
    drive("flush0", 0, 0, 0, 0, 1);
    drive("pushX", 1, 32'h11, 0, 0, 0);
    drive("pushY", 1, 32'h22, 0, 0, 0);
    drive("pop_empty3", 0, 0, 1, 3, 0); chk("pop_empty.lit", 128'(malloc), 128'(4'b0011));

    // Flush beats push and pop
    drive("pushZ", 1, 32'h33, 0, 0, 0);
    drive("pushW", 1, 32'h44, 0, 0, 0); chk("refill.lit", 128'(malloc), 128'(4'b1111));
    drive("flush_push_pop", 1, 32'h55, 1, 1, 1); chk("flush.lit", 128'(malloc), 128'(4'b0000));

    // Age ordering scenario
    drive("age_p0", 1, 32'h100, 0, 0, 0);
    drive("age_p1", 1, 32'h101, 0, 0, 0);
    drive("age_p2", 1, 32'h102, 0, 0, 0);
    drive("age_pop0", 0, 0, 1, 0, 0);
    drive("age_pushG", 1, 32'h6, 0, 0, 0); chk("age_G.lit", 128'(malloc), 128'(4'b0111));
`ifdef SHIFT_ISSUE_BUF_AGE_EN
    chk("oldest_a.lit", 128'(oldest), 128'(4'b0010));
`endif
    drive("age_pop1", 0, 0, 1, 1, 0);
`ifdef SHIFT_ISSUE_BUF_AGE_EN
    chk("oldest_b.lit", 128'(oldest), 128'(4'b0100));
`endif
    drive("age_pop2", 0, 0, 1, 2, 0);
`ifdef SHIFT_ISSUE_BUF_AGE_EN
    chk("oldest_c.lit", 128'(oldest), 128'(4'b0001));
`endif

    // Asynchronous reset mid-cycle
    drive("pre_rst", 1, 32'h77, 0, 0, 0);
    push = 0; pop = 0; fl = 0;
    #3;
    RSTn = 1'b0;
    #1;
    m_reset();
    check_all("async_rst");
    chk("async_rst.lit", 128'(malloc), 128'(4'b0000));
    @(negedge CLK);
    RSTn = 1'b1;

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      drive("rand", 1'($urandom % 4 != 0), DW'($urandom), 1'($urandom % 2),
            IW'($urandom % DEPTH), 1'($urandom % 20 == 0));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
